// File: rtl/twos_to_float_pipe_pkg.sv
// Shared widths, saturation constants and stage records for the
// two's-complement to small-float converter family.
package twos_to_float_pipe_pkg;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int LZ_W  = 4;

  localparam logic [IN_W-1:0]  IN_MIN  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]  MAG_SAT = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [LZ_W-1:0]  LZ_CAP  = LZ_W'(8);
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [SIG_W-1:0] SIG_MAX = {SIG_W{1'b1}};
  localparam logic [SIG_W-1:0] SIG_OVF = {1'b1, {(SIG_W-1){1'b0}}};

  typedef struct packed {
    logic            valid;
    logic            sign;
    logic [IN_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [IN_W-1:0]  mag;
    logic [EXP_W-1:0] e_raw;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } s3_t;

  // The most negative input has no positive twin; clamp it to the largest magnitude.
  function automatic logic [IN_W-1:0] abs_sat(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] r;
    if (!d[IN_W-1])      r = d;
    else if (d == IN_MIN) r = MAG_SAT;
    else                 r = -d;
    return r;
  endfunction

endpackage

// File: rtl/twos_to_float_pipe_if.sv
// Input and output handshake bundle of the converter.
// valid/ready: a beat transfers on a rising clk edge where valid && ready are both 1;
// the producer holds its data stable while valid is high and ready is low.
interface twos_to_float_pipe_if;
  import twos_to_float_pipe_pkg::*;

  logic [IN_W-1:0]  d;
  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic [EXP_W-1:0] e;
  logic [SIG_W-1:0] f;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  d, in_valid, out_ready,
    output in_ready, s, e, f, out_valid
  );

  modport master (
    output d, in_valid, out_ready,
    input  in_ready, s, e, f, out_valid
  );

endinterface

// File: rtl/twos_to_float_pipe_priority_encoder.sv
// Leading-zero count of a 12-bit magnitude whose MSB is known to be 0,
// given bits [10:0]; result is 1..8 (capped at 8).
module priority_encoder
  import twos_to_float_pipe_pkg::*;
(
  input  logic [IN_W-2:0] in_i,
  output logic [LZ_W-1:0] lz_o
);

  // Ascending scan so the highest set bit wins; bits below 4 all map to the cap.
  always_comb begin
    lz_o = LZ_CAP;
    for (int i = 0; i < IN_W - 1; i++) begin
      if (in_i[i]) begin
        lz_o = (i <= 3) ? LZ_CAP : LZ_W'(IN_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/twos_to_float_pipe.sv
// Three-stage converter: S1 absolute value, S2 leading-zero count,
// S3 normalise/round into a sign + 3-bit exponent + 4-bit significand.
module twos_to_float_pipe
  import twos_to_float_pipe_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  twos_to_float_pipe_if.slave bus
);

  logic adv;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  s3_t  s3_q, s3_d;

  logic [LZ_W-1:0]  lz;
  logic [SIG_W:0]   sh;
  logic [SIG_W:0]   rsum;
  logic [EXP_W:0]   e_ext;

  // One enable for the whole pipe: it moves only when the output slot is free.
  assign adv          = !s3_q.valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    s1_d       = '0;
    s1_d.valid = bus.in_valid;
    s1_d.sign  = bus.d[IN_W-1];
    s1_d.mag   = abs_sat(bus.d);
  end

  priority_encoder u_lzc (
    .in_i (s1_q.mag[IN_W-2:0]),
    .lz_o (lz)
  );

  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.sign  = s1_q.sign;
    s2_d.mag   = s1_q.mag;
    s2_d.e_raw = EXP_W'(LZ_CAP - lz);
  end

  // sh[0] is the round bit and sh[SIG_W:1] the kept significand.
  always_comb begin
    s3_d       = '0;
    sh         = '0;
    rsum       = '0;
    e_ext      = '0;
    s3_d.valid = s2_q.valid;
    s3_d.sign  = s2_q.sign;
    if (s2_q.e_raw == '0) begin
      s3_d.exp = '0;
      s3_d.sig = s2_q.mag[SIG_W-1:0];
    end else begin
      sh   = (SIG_W+1)'(s2_q.mag >> (s2_q.e_raw - EXP_ONE));
      rsum = {1'b0, sh[SIG_W:1]} + {{SIG_W{1'b0}}, sh[0]};
      if (rsum[SIG_W]) begin
        e_ext = {1'b0, s2_q.e_raw} + {1'b0, EXP_ONE};
        if (e_ext[EXP_W]) begin
          s3_d.exp = EXP_MAX;
          s3_d.sig = SIG_MAX;
        end else begin
          s3_d.exp = e_ext[EXP_W-1:0];
          s3_d.sig = SIG_OVF;
        end
      end else begin
        s3_d.exp = s2_q.e_raw;
        s3_d.sig = rsum[SIG_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.out_valid = s3_q.valid;
  assign bus.s         = s3_q.sign;
  assign bus.e         = s3_q.exp;
  assign bus.f         = s3_q.sig;

endmodule

// File: tb/tb_twos_to_float_pipe.sv
// Directed and sweep bench for twos_to_float_pipe; expected {s,e,f} packed as 8 bits.
module tb_twos_to_float_pipe;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];

  twos_to_float_pipe_if bus();

  twos_to_float_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion built from integer arithmetic.
  function automatic logic [7:0] model(input logic [11:0] d);
    int v, m, msb, ex, r;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    if (m < 16) begin
      ex = 0;
      r  = m;
    end else begin
      msb = 0;
      for (int b = 0; b < 12; b++) if (((m >> b) & 1) == 1) msb = b;
      ex = msb - 3;
      r  = (m + (1 << (ex - 1))) >> ex;
      if (r == 16) begin
        ex = ex + 1;
        r  = 8;
      end
      if (ex >= 8) begin
        ex = 7;
        r  = 15;
      end
    end
    return {d[11], 3'(ex), 4'(r)};
  endfunction

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.d         = 12'h5A5;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if ({bus.s, bus.e, bus.f} !== 8'h00) begin
      errors++;
      $display("FAIL reset_sef got=%h exp=00", {bus.s, bus.e, bus.f});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_dropped_input got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_latency();
    bus.d         = 12'h07D;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (bus.out_valid !== (k == 3)) begin
        errors++;
        $display("FAIL latency_valid cycle=%0d got=%b exp=%b", k, bus.out_valid, (k == 3));
      end
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if ({bus.s, bus.e, bus.f} !== 8'h48) begin
      errors++;
      $display("FAIL latency_value got=%h exp=48", {bus.s, bus.e, bus.f});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors();
    logic [11:0] dv[6];
    logic [7:0]  ev[6];
    int sent, got, cyc;
    dv = '{12'h07D, 12'h1A6, 12'hFFF, 12'h800, 12'h7FF, 12'h000};
    ev = '{8'h48,   8'h5D,   8'h81,   8'hFF,   8'h7F,   8'h00};
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    while ((sent < 6 || exp_q.size() != 0) && cyc < 40) begin
      bus.d         = (sent < 6) ? dv[sent] : 12'h000;
      bus.in_valid  = (sent < 6);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL vec_unexpected got=%h", {bus.s, bus.e, bus.f});
        end else if ({bus.s, bus.e, bus.f} !== exp_q[0]) begin
          errors++;
          $display("FAIL vec_value idx=%0d got=%h exp=%h", got, {bus.s, bus.e, bus.f}, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ev[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (got != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL vec_count got=%0d exp=6 pending=%0d", got, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] dv[8];
    logic [7:0]  ev[8];
    int sent, got, cyc;
    dv = '{12'h010, 12'h00F, 12'hFEF, 12'h01F, 12'hF9C, 12'h3E8, 12'hC18, 12'h400};
    ev = '{8'h18,   8'h0F,   8'h99,   8'h28,   8'hBD,   8'h78,   8'hF8,   8'h78};
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    while ((sent < 8 || exp_q.size() != 0) && cyc < 40) begin
      bus.d         = (sent < 8) ? dv[sent] : 12'h000;
      bus.in_valid  = (sent < 8);
      bus.out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready,
                 (!bus.out_valid || bus.out_ready));
      end
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected got=%h", {bus.s, bus.e, bus.f});
        end else if ({bus.s, bus.e, bus.f} !== exp_q[0]) begin
          errors++;
          $display("FAIL b2b_value cyc=%0d got=%h exp=%h", cyc, {bus.s, bus.e, bus.f}, exp_q[0]);
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ev[sent]);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=8 pending=%0d", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.d = 12'h100 + 12'(k);
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_inflight got=%b exp=1", bus.out_valid);
    end
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    bus.d         = 12'h123;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.s, bus.e, bus.f} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_clear got=%b/%h exp=0/00", bus.out_valid, {bus.s, bus.e, bus.f});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_ready got=%b exp=1", bus.in_ready);
    end
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale cycle=%0d got=%b exp=0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_sweep();
    int sent, got, cyc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    while ((sent < 4096 || exp_q.size() != 0) && cyc < 40000) begin
      bus.d         = 12'(sent);
      bus.in_valid  = (sent < 4096) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep_unexpected got=%h", {bus.s, bus.e, bus.f});
        end else if ({bus.s, bus.e, bus.f} !== exp_q[0]) begin
          errors++;
          $display("FAIL sweep_value idx=%0d got=%h exp=%h", got, {bus.s, bus.e, bus.f}, exp_q[0]);
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.d));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (got != 4096 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_count got=%0d exp=4096 pending=%0d", got, exp_q.size());
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.d         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_midstream();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/twos_to_float_pipe.md
TWOS_TO_FLOAT_PIPE -- requirements
Module: twos_to_float_pipe

Interface
REQ-001 clk  input  1  rising-edge clock; the block uses one clock only.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 d  input  12  two's-complement sample.
REQ-004 in_valid  input  1  d is valid this cycle.
REQ-005 in_ready  output  1  the block accepts d this cycle.
REQ-006 s  output  1  sign of the result.
REQ-007 e  output  3  exponent; value = f * 2^e.
REQ-008 f  output  4  significand.
REQ-009 out_valid  output  1  s/e/f are valid.
REQ-010 out_ready  input  1  downstream accepts the result.

Function
REQ-011 The block SHALL be a 3-stage pipeline (S1 abs, S2 leading-zero count, S3 normalize/round) with one valid bit per stage.
REQ-012 Global enable adv = !out_valid || out_ready; in_ready SHALL equal adv, and all stages SHALL shift together only when adv=1.
REQ-013 An input is accepted when in_valid && in_ready; its result SHALL appear on out_valid exactly 3 cycles later if adv stays high.
REQ-014 Throughput SHALL be 1 result/cycle while out_ready=1; bubbles SHALL propagate as invalid stages and are not collapsed.
REQ-015 While out_valid && !out_ready, s/e/f/out_valid and all stage registers SHALL hold unchanged.
REQ-016 S1: sign = d[11]; mag = |d| as 12 bits; d = -2048 SHALL saturate to mag = 2047.
REQ-017 S2: lz = leading-zero count of mag[11:0], capped at 8 (range 1..8, since mag[11]=0); e_raw = 8 - lz.
REQ-018 S3, e_raw = 0: f = mag[3:0], e = 0, no rounding.
REQ-019 S3, e_raw >= 1: f = mag[e_raw+3:e_raw], rnd = mag[e_raw-1]; if rnd=1, f = f + 1.
REQ-020 Rounding overflow (f = 15 + 1): f = 8 and e = e_raw + 1.
REQ-021 If e = 8 after REQ-020, the output SHALL saturate to e = 7, f = 15.
REQ-022 s SHALL be the S1 sign for every nonzero input; d = 0 SHALL give s = 0, e = 0, f = 0.
REQ-023 The module SHALL carry no data-dependent stalls; in_ready depends only on out_valid and out_ready.

Reset
REQ-024 On a clk edge with rst_n=0, all stage valids and out_valid SHALL clear to 0, and s/e/f SHALL clear to 0.
REQ-025 Reset mid-stream SHALL discard all in-flight samples; none SHALL emerge after reset.
REQ-026 During reset, in_ready SHALL read 1, because out_valid=0; inputs presented while rst_n=0 SHALL be dropped.

Structure
REQ-027 Widths IN_W=12, EXP_W=3, SIG_W=4 and the saturation constants SHALL live in the shared twos_float package/include used by the converter family.
REQ-028 The S2 leading-zero count SHALL be one instance of the existing priority_encoder sub-module, fed mag[10:0], output 1..8 = lz; no other sub-modules.
REQ-029 The design SHALL be fully synchronous, with no latches and no combinational path from d to s/e/f.

Verification
REQ-030 d=0x07D (125), out_ready=1 -> 3 cycles later s=0, e=4, f=8, covering round overflow.
REQ-031 d=0x1A6 (422) -> s=0, e=5, f=13; d=0xFFF (-1) -> s=1, e=0, f=1.
REQ-032 d=0x800 (-2048) and d=0x7FF (2047) -> s=1/0 respectively, e=7, f=15 (saturation).
REQ-033 Stream of 8 back-to-back samples with out_ready low for 3 cycles mid-burst -> outputs hold while stalled, all 8 results in order, none lost or duplicated.
REQ-034 rst_n pulsed low for 1 cycle with 3 samples in flight -> out_valid=0 next cycle, no stale result ever emitted.
REQ-035 Random 10k samples vs. golden model of REQ-016..022 with random in_valid/out_ready -> zero mismatches; every d in -2048..2047 hit at least once.
